// File: rtl/rv32i_control_fsm_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: state encoding,
// decoder flag bit positions and datapath mux selects.
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXECUTE,
    LOAD,
    STORE,
    HALT
  } state_t;

  localparam int NFLAGS    = 10;
  localparam int FL_ALUREG = 0;
  localparam int FL_ALUIMM = 1;
  localparam int FL_BRANCH = 2;
  localparam int FL_JALR   = 3;
  localparam int FL_JAL    = 4;
  localparam int FL_AUIPC  = 5;
  localparam int FL_LUI    = 6;
  localparam int FL_LOAD   = 7;
  localparam int FL_STORE  = 8;
  localparam int FL_SYSTEM = 9;

  typedef enum logic [1:0] {
    WSEL_ALU,
    WSEL_LOAD,
    WSEL_PC4,
    WSEL_UIMM
  } rf_wsel_t;

  typedef enum logic [1:0] {
    PCSEL_PC4,
    PCSEL_BRANCH,
    PCSEL_JALR
  } pc_sel_t;

  // States that hold a request on the shared memory port.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == LOAD) || (s == STORE);
  endfunction

endpackage

// File: rtl/rv32i_control_fsm_if.sv
// Decoder/memory/datapath signal bundle between the sequencer (master)
// and the surrounding core (slave).
interface rv32i_control_fsm_if #(
  parameter int CNT_W = 32
);
  import rv32i_ctrl_pkg::*;

  logic [NFLAGS-1:0] dec_flags;
  logic              take_branch;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic              mem_addr_sel;
  logic              ir_we;
  logic              rf_we;
  rf_wsel_t          rf_wsel;
  logic              pc_we;
  pc_sel_t           pc_sel;
  logic              halted;
  logic              bus_err;
  logic [CNT_W-1:0]  instret;
  state_t            state_o;

  modport master (
    input  dec_flags, take_branch, mem_ack,
    output mem_req, mem_we, mem_addr_sel, ir_we, rf_we, rf_wsel,
           pc_we, pc_sel, halted, bus_err, instret, state_o
  );

  modport slave (
    output dec_flags, take_branch, mem_ack,
    input  mem_req, mem_we, mem_addr_sel, ir_we, rf_we, rf_wsel,
           pc_we, pc_sel, halted, bus_err, instret, state_o
  );

endinterface

// File: rtl/rv32i_control_fsm_watchdog.sv
// Memory-request watchdog: down-counter reloaded whenever the port is idle
// or acknowledged; expires on the TIMEOUT_CYCLES-th consecutive unacked cycle.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int          W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

  logic [W-1:0] cnt_q;
  logic         stall;

  assign stall = active_i & ~ack_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_q <= '0;
    else if (stall) cnt_q <= cnt_q - W'(1);
    else            cnt_q <= LOAD_VAL;
  end

  // An ack in the terminal cycle suppresses expiry.
  assign expire_o = (TIMEOUT_CYCLES != 0) && stall && (cnt_q == '0);

endmodule

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle fetch/execute/load/store sequencer for the RV32I core, with
// retired-instruction counter and memory-timeout watchdog.
module rv32i_control_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rv32i_control_fsm_if.master  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             bus_err_q;
  logic             retire;
  logic             mem_phase;
  logic             wd_expire;

  assign mem_phase = is_mem_state(state_q);

  mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .active_i (mem_phase),
    .ack_i    (bus.mem_ack),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d          = state_q;
    retire           = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.rf_we        = 1'b0;
    bus.rf_wsel      = WSEL_ALU;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = PCSEL_PC4;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_we = 1'b1;
          state_d   = EXECUTE;
        end
      end
      EXECUTE: begin
        if (bus.dec_flags[FL_LOAD])                                 state_d = LOAD;
        else if (bus.dec_flags[FL_STORE])                           state_d = STORE;
        else if (bus.dec_flags[FL_SYSTEM] || bus.dec_flags == '0)   state_d = HALT;
        else begin
          bus.pc_we = 1'b1;
          bus.rf_we = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
          // AUIPC shares the ALU path: the ALU adds PC and the U-immediate.
          if (bus.dec_flags[FL_JAL]) begin
            bus.rf_wsel = WSEL_PC4;
            bus.pc_sel  = PCSEL_BRANCH;
          end else if (bus.dec_flags[FL_JALR]) begin
            bus.rf_wsel = WSEL_PC4;
            bus.pc_sel  = PCSEL_JALR;
          end else if (bus.dec_flags[FL_BRANCH]) begin
            bus.rf_we  = 1'b0;
            bus.pc_sel = bus.take_branch ? PCSEL_BRANCH : PCSEL_PC4;
          end else if (bus.dec_flags[FL_LUI]) begin
            bus.rf_wsel = WSEL_UIMM;
          end
        end
      end
      LOAD: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        if (bus.mem_ack) begin
          bus.rf_we   = 1'b1;
          bus.rf_wsel = WSEL_LOAD;
          bus.pc_we   = 1'b1;
          retire      = 1'b1;
          state_d     = FETCH;
        end
      end
      STORE: begin
        bus.mem_req      = 1'b1;
        bus.mem_we       = 1'b1;
        bus.mem_addr_sel = 1'b1;
        if (bus.mem_ack) begin
          bus.pc_we = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = state_q;
    endcase
    if (wd_expire) state_d = HALT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)    instret_q <= instret_q + CNT_W'(1);
      if (wd_expire) bus_err_q <= 1'b1;
    end
  end

  assign bus.halted  = (state_q == HALT);
  assign bus.bus_err = bus_err_q;
  assign bus.instret = instret_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Bench for rv32i_control_fsm: execute-class vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_rv32i_control_fsm;
  import rv32i_ctrl_pkg::*;

  localparam int TO = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;

  rv32i_control_fsm_if #(.CNT_W(CW)) bus ();

  rv32i_control_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  state_t        m_st;
  int            m_wd;
  logic          m_err;
  logic [CW-1:0] m_ir;

  typedef struct {
    logic [9:0] flags;
    logic       take;
    logic       rf;
    rf_wsel_t   wsel;
    logic       pcw;
    pc_sel_t    psel;
    state_t     nxt;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [9:0] fb(input int i);
    logic [9:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void exec_class(input logic [9:0] f, input logic tk,
                                     output logic rf, output rf_wsel_t ws, output pc_sel_t ps);
    rf = 1'b1;
    ws = WSEL_ALU;
    ps = PCSEL_PC4;
    if (f[FL_JAL])         begin ws = WSEL_PC4; ps = PCSEL_BRANCH; end
    else if (f[FL_JALR])   begin ws = WSEL_PC4; ps = PCSEL_JALR; end
    else if (f[FL_BRANCH]) begin rf = 1'b0; ps = tk ? PCSEL_BRANCH : PCSEL_PC4; end
    else if (f[FL_LUI])    ws = WSEL_UIMM;
  endfunction

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic step(input logic [9:0] f, input logic tk, input logic ack, input string tag);
    logic e_req, e_we, e_as, e_ir, e_rf, e_pcw, ret;
    rf_wsel_t e_ws;
    pc_sel_t  e_ps;
    state_t   nx;
    logic [63:0] a, e;
    @(negedge clk);
    bus.dec_flags   = f;
    bus.take_branch = tk;
    bus.mem_ack     = ack;
    #1;
    e_req = 0; e_we = 0; e_as = 0; e_ir = 0; e_rf = 0; e_pcw = 0; ret = 0;
    e_ws = WSEL_ALU; e_ps = PCSEL_PC4; nx = m_st;
    case (m_st)
      IDLE: nx = FETCH;
      FETCH: begin
        e_req = 1;
        if (ack) begin e_ir = 1; nx = EXECUTE; end
      end
      EXECUTE: begin
        if (f[FL_LOAD]) nx = LOAD;
        else if (f[FL_STORE]) nx = STORE;
        else if (f[FL_SYSTEM] || f == '0) nx = HALT;
        else begin
          exec_class(f, tk, e_rf, e_ws, e_ps);
          e_pcw = 1; ret = 1; nx = FETCH;
        end
      end
      LOAD: begin
        e_req = 1; e_as = 1;
        if (ack) begin e_rf = 1; e_ws = WSEL_LOAD; e_pcw = 1; ret = 1; nx = FETCH; end
      end
      STORE: begin
        e_req = 1; e_we = 1; e_as = 1;
        if (ack) begin e_pcw = 1; ret = 1; nx = FETCH; end
      end
      default: ;
    endcase
    a = {bus.mem_req, e_req & bus.mem_we, e_req & bus.mem_addr_sel, bus.ir_we, bus.rf_we,
         (e_rf ? bus.rf_wsel : WSEL_ALU), bus.pc_we, (e_pcw ? bus.pc_sel : PCSEL_PC4),
         bus.halted, bus.bus_err, bus.instret, bus.state_o};
    e = {e_req, e_we, e_as, e_ir, e_rf, e_ws, e_pcw, e_ps,
         (m_st == HALT), m_err, m_ir, m_st};
    check($sformatf("%s_%s", tag, m_st.name()), a, e);
    if (e_req) begin
      if (ack) m_wd = 0;
      else begin
        m_wd++;
        if (m_wd == TO) begin nx = HALT; m_err = 1; end
      end
    end else m_wd = 0;
    if (ret) m_ir = m_ir + 1'b1;
    m_st = nx;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("reset_outputs",
          {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.rf_we, bus.rf_wsel,
           bus.pc_we, bus.pc_sel, bus.halted, bus.bus_err, bus.instret, bus.state_o},
          {13'd0, CW'(0), IDLE});
    m_st = IDLE; m_wd = 0; m_err = 0; m_ir = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n_req, n_rf, ack_pct, r;
    logic [9:0] f;

    reset = 1'b1;
    bus.dec_flags = '0; bus.take_branch = 1'b0; bus.mem_ack = 1'b0;

    vecs[0]  = '{fb(FL_ALUREG),            1'b0, 1'b1, WSEL_ALU,  1'b1, PCSEL_PC4,    FETCH};
    vecs[1]  = '{fb(FL_ALUIMM),            1'b0, 1'b1, WSEL_ALU,  1'b1, PCSEL_PC4,    FETCH};
    vecs[2]  = '{fb(FL_LUI),               1'b0, 1'b1, WSEL_UIMM, 1'b1, PCSEL_PC4,    FETCH};
    vecs[3]  = '{fb(FL_AUIPC),             1'b1, 1'b1, WSEL_ALU,  1'b1, PCSEL_PC4,    FETCH};
    vecs[4]  = '{fb(FL_JAL),               1'b0, 1'b1, WSEL_PC4,  1'b1, PCSEL_BRANCH, FETCH};
    vecs[5]  = '{fb(FL_JALR),              1'b0, 1'b1, WSEL_PC4,  1'b1, PCSEL_JALR,   FETCH};
    vecs[6]  = '{fb(FL_BRANCH),            1'b1, 1'b0, WSEL_ALU,  1'b1, PCSEL_BRANCH, FETCH};
    vecs[7]  = '{fb(FL_BRANCH),            1'b0, 1'b0, WSEL_ALU,  1'b1, PCSEL_PC4,    FETCH};
    vecs[8]  = '{fb(FL_LOAD)|fb(FL_ALUREG),1'b0, 1'b0, WSEL_ALU,  1'b0, PCSEL_PC4,    LOAD};
    vecs[9]  = '{fb(FL_STORE)|fb(FL_BRANCH),1'b1,1'b0, WSEL_ALU,  1'b0, PCSEL_PC4,    STORE};
    vecs[10] = '{fb(FL_LOAD)|fb(FL_STORE), 1'b0, 1'b0, WSEL_ALU,  1'b0, PCSEL_PC4,    LOAD};
    vecs[11] = '{fb(FL_SYSTEM),            1'b0, 1'b0, WSEL_ALU,  1'b0, PCSEL_PC4,    HALT};
    vecs[12] = '{10'd0,                    1'b0, 1'b0, WSEL_ALU,  1'b0, PCSEL_PC4,    HALT};
    vecs[13] = '{fb(FL_SYSTEM)|fb(FL_JAL), 1'b0, 1'b0, WSEL_ALU,  1'b0, PCSEL_PC4,    HALT};

    do_reset();

    // Reset release, ALUimm with ack on the first FETCH cycle
    step('0, 0, 0, "t1");
    step('0, 0, 1, "t1");
    step(fb(FL_ALUIMM), 0, 0, "t1");
    step('0, 0, 0, "t1");
    check("t1_instret", bus.instret, 1);
    step('0, 0, 1, "t1");
    step(fb(FL_JAL), 0, 0, "t1");

    for (int i = 0; i < 14; i++) begin
      step('0, 0, 1, "vfetch");
      step(vecs[i].flags, vecs[i].take, 0, "vexec");
      check($sformatf("vec%0d_exec", i),
            {bus.rf_we, (vecs[i].rf ? bus.rf_wsel : WSEL_ALU), bus.pc_we,
             (vecs[i].pcw ? bus.pc_sel : PCSEL_PC4)},
            {vecs[i].rf, vecs[i].wsel, vecs[i].pcw, vecs[i].psel});
      @(posedge clk);
      #1 check($sformatf("vec%0d_next", i), bus.state_o, vecs[i].nxt);
      if (vecs[i].nxt == LOAD || vecs[i].nxt == STORE) step('0, 0, 1, "vmem");
      else if (vecs[i].nxt == HALT) begin
        repeat (3) step(fb(FL_ALUIMM), 0, 1, "vhalt");
        check($sformatf("vec%0d_stuck", i), {bus.halted, bus.state_o}, {1'b1, HALT});
        do_reset();
        step('0, 0, 0, "vidle");
      end
    end

    // Load with ack delayed by 3 cycles
    step('0, 0, 1, "t3");
    step(fb(FL_LOAD), 0, 0, "t3");
    n_req = 0; n_rf = 0;
    for (int k = 0; k < 4; k++) begin
      step('0, 0, (k == 3), "t3");
      if (bus.mem_req && bus.mem_addr_sel) n_req++;
      if (bus.rf_we) n_rf++;
    end
    check("t3_req_cycles", n_req, 4);
    check("t3_rf_we_cycles", n_rf, 1);

    // Store with ack after 1 cycle
    step('0, 0, 1, "t4");
    step(fb(FL_STORE), 0, 0, "t4");
    step('0, 0, 0, "t4");
    step('0, 0, 1, "t4");

    // Watchdog expiry with no ack
    for (int k = 0; k < TO; k++) step('0, 0, 0, "t5");
    step('0, 0, 1, "t5");
    check("t5_timeout", {bus.state_o, bus.bus_err, bus.mem_req, bus.halted}, {HALT, 3'b101});
    do_reset();
    step('0, 0, 0, "t5b");
    for (int k = 0; k < TO - 1; k++) step('0, 0, 0, "t5b");
    step('0, 0, 1, "t5b");
    step(fb(FL_ALUIMM), 0, 0, "t5b");
    check("t5_ack_at_limit", {bus.bus_err, bus.state_o}, {1'b0, EXECUTE});

    // Reset mid-LOAD
    step('0, 0, 1, "t6");
    step(fb(FL_LOAD), 0, 0, "t6");
    step('0, 0, 0, "t6");
    do_reset();
    step('0, 0, 0, "t6");

    // instret wraps at 2^CW
    for (int k = 0; k < 260; k++) begin
      step('0, 0, 1, "wrap");
      step(fb(FL_ALUIMM), 0, 0, "wrap");
    end
    step('0, 0, 0, "wrap");
    check("instret_wrap", bus.instret, 4);
    do_reset();

    ack_pct = 75;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) ack_pct = ($urandom_range(0, 3) == 0) ? 5 : 75;
      r = $urandom_range(0, 99);
      if (r < 3)       f = '0;
      else if (r < 6)  f = fb(FL_SYSTEM);
      else if (r < 80) f = fb($urandom_range(0, 8));
      else             f = 10'($urandom) | fb($urandom_range(0, 1) ? FL_LOAD : FL_STORE);
      step(f, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < ack_pct), "rand");
      if (m_st == HALT && $urandom_range(0, 3) == 0) do_reset();
      else if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
